// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx
//   Asynchronous serial receiver. Frames are 1 start bit (low), PAYLOAD_BITS
//   data bits sent LSB first, and 1 stop bit (high), with no parity. The line is
//   oversampled with the system clock, and each bit is sampled at its centre.
//
// Ports
//   clock             system clock, rising edge
//   reset             asynchronous, active-high reset
//   io_i_serial_data  serial line, idle high, asynchronous to clock
//   io_o_rx_done      one-cycle pulse: a valid frame was received and
//                     io_o_data was updated in that cycle
//   io_o_data         last correctly received word, held until the next valid
//                     frame arrives
module uart_rx #(
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned CLK_FREQ     = 16000000,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_i_serial_data,
  output logic                    io_o_rx_done,
  output logic [PAYLOAD_BITS-1:0] io_o_data
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BIT_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned IDX_W        = $clog2(PAYLOAD_BITS) + 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        clk_cnt, clk_cnt_nxt;
  logic [IDX_W-1:0]        bit_idx, bit_idx_nxt;
  logic [PAYLOAD_BITS-1:0] shift_reg, shift_nxt;
  logic [PAYLOAD_BITS-1:0] data_nxt;
  logic                    done_nxt;
  logic                    sync_1, rx_s;

  // Two-flop synchronizer. The flops reset to 1 so that reset looks like an
  // idle line rather than a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= io_i_serial_data;
      rx_s   <= sync_1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      io_o_data    <= '0;
      io_o_rx_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      clk_cnt      <= clk_cnt_nxt;
      bit_idx      <= bit_idx_nxt;
      shift_reg    <= shift_nxt;
      io_o_data    <= data_nxt;
      io_o_rx_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_reg;
    data_nxt    = io_o_data;
    done_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        bit_idx_nxt = '0;
        if (!rx_s) state_nxt = START;
      end

      // Recheck the line at the middle of the start bit. This rejects glitches
      // shorter than half a bit.
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          for (int unsigned i = 0; i < PAYLOAD_BITS; i++) begin
            if (bit_idx == IDX_W'(i)) shift_nxt[i] = rx_s;
          end
          if (bit_idx == IDX_LAST) begin
            bit_idx_nxt = '0;
            state_nxt   = STOP;
          end else begin
            bit_idx_nxt = bit_idx + IDX_W'(1);
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      // The FSM leaves at mid-stop-bit so that a start bit directly after the
      // stop bit is not missed.
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shift_reg;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_HI;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      // After a framing error, wait for the line to return high. This stops a
      // break condition from being read as a stream of start bits.
      WAIT_HI: begin
        clk_cnt_nxt = '0;
        bit_idx_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx
//   Self-checking bench for uart_rx at 115200 bit/s with a 16 MHz clock and
//   8-bit payload. Serial frames are driven bit-accurately. Received words,
//   pulse counts and done latency are compared against expected values.
module tb_uart_rx;

  localparam int unsigned BIT_RATE = 115200;
  localparam int unsigned CLK_FREQ = 16000000;
  localparam int unsigned CPB      = CLK_FREQ / BIT_RATE;
  // (8 + 1.5) bit periods plus 3 clocks of synchronizer/register latency
  localparam int unsigned DONE_LAT = 9 * CPB + CPB / 2 + 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       line  = 1'b1;
  logic       rx_done;
  logic [7:0] rx_data;

  uart_rx #(
    .BIT_RATE    (BIT_RATE),
    .CLK_FREQ    (CLK_FREQ),
    .PAYLOAD_BITS(8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .io_i_serial_data(line),
    .io_o_rx_done    (rx_done),
    .io_o_data       (rx_data)
  );

  always #31.25 clock = ~clock;

  int unsigned tests    = 0;
  int unsigned fails    = 0;
  int unsigned cyc      = 0;
  int unsigned pulses   = 0;
  int unsigned done_cyc = 0;
  logic        prev_done = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic [7:0]  model     = 8'h00;

  typedef struct {
    logic [7:0]  b;
    bit          stop_ok;
    int unsigned gap;
    int unsigned exp_done;
    logic [7:0]  exp_data;
  } vec_t;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // Pulse monitor: counts done pulses, flags consecutive pulses, and flags any
  // change of the data output outside a done cycle.
  always @(negedge clock) begin
    if (rx_done) begin
      pulses++;
      done_cyc = cyc;
      check("done not back-to-back", 32'(prev_done), 0);
    end else if (!reset && rx_data !== prev_data) begin
      tests++;
      fails++;
      $display("FAIL data stable: changed 0x%0h -> 0x%0h without done", prev_data, rx_data);
    end
    prev_done = rx_done;
    prev_data = rx_data;
  end

  // Assumes the caller is at a negedge. Returns at the negedge that ends the
  // stop bit, with the line left high.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, output int unsigned t0);
    t0   = cyc;
    line = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (CPB) @(negedge clock);
    end
    line = stop_ok;
    repeat (CPB) @(negedge clock);
    line = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] b, input bit stop_ok, input int unsigned gap,
                           input string tag, input int unsigned exp_done,
                           input logic [7:0] exp_data);
    int unsigned p0, t0, lat;
    p0 = pulses;
    send_frame(b, stop_ok, t0);
    check({tag, " pulses"}, pulses - p0, exp_done);
    check({tag, " data"}, 32'(rx_data), 32'(exp_data));
    if (exp_done != 0) begin
      lat = done_cyc - t0;
      if (lat + 2 < DONE_LAT || lat > DONE_LAT + 2) begin
        tests++;
        fails++;
        $display("FAIL %s latency: got %0d expected %0d +/-2", tag, lat, DONE_LAT);
      end else begin
        tests++;
      end
    end
    repeat (gap) @(negedge clock);
  endtask

  vec_t vecs[9];

  initial begin
    int unsigned p0, t0;
    logic [7:0]  v3c;
    logic [7:0]  rb;
    bit          rok;
    int unsigned rgap;

    vecs[0] = '{8'h16, 1'b1, 0,  1, 8'h16};
    vecs[1] = '{8'h32, 1'b1, 0,  1, 8'h32};
    vecs[2] = '{8'hAF, 1'b1, 20, 1, 8'hAF};
    vecs[3] = '{8'h55, 1'b0, 20, 0, 8'hAF};
    vecs[4] = '{8'hA5, 1'b1, 20, 1, 8'hA5};
    vecs[5] = '{8'h00, 1'b1, 0,  1, 8'h00};
    vecs[6] = '{8'hFF, 1'b1, 0,  1, 8'hFF};
    vecs[7] = '{8'h80, 1'b0, 20, 0, 8'hFF};
    vecs[8] = '{8'h01, 1'b1, 20, 1, 8'h01};

    // Reset state and quiet idle line.
    #62;
    check("reset data", 32'(rx_data), 0);
    check("reset done", 32'(rx_done), 0);
    #1 reset = 1'b0;
    @(negedge clock);
    repeat (300) @(negedge clock);
    check("idle pulses", pulses, 0);
    check("idle data", 32'(rx_data), 0);

    // Table of frames: back-to-back frames, framing errors and edge patterns.
    foreach (vecs[k]) begin
      run_frame(vecs[k].b, vecs[k].stop_ok, vecs[k].gap, $sformatf("vec%0d", k),
                vecs[k].exp_done, vecs[k].exp_data);
      model = vecs[k].exp_data;
    end

    // 2 us low glitch on an idle line.
    p0   = pulses;
    line = 1'b0;
    repeat (32) @(negedge clock);
    line = 1'b1;
    repeat (300) @(negedge clock);
    check("glitch pulses", pulses - p0, 0);
    check("glitch data", 32'(rx_data), 32'(model));
    run_frame(8'hC3, 1'b1, 10, "post-glitch", 1, 8'hC3);
    model = 8'hC3;

    // Reset in the middle of data bit 3. Reset must clear the outputs
    // immediately, with no clock edge needed.
    v3c  = 8'h3C;
    t0   = cyc;
    line = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      line = v3c[i];
      repeat (CPB) @(negedge clock);
    end
    line = v3c[3];
    repeat (CPB / 2) @(negedge clock);
    #10 reset = 1'b1;
    #1;
    check("async reset data", 32'(rx_data), 0);
    check("async reset done", 32'(rx_done), 0);
    model = 8'h00;
    line  = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("post-reset data", 32'(rx_data), 0);
    run_frame(8'h3C, 1'b1, 10, "post-reset", 1, 8'h3C);
    model = 8'h3C;

    // Random frames. The model holds the last word whose stop bit was good.
    for (int n = 0; n < 30; n++) begin
      rb   = 8'($urandom_range(255));
      rok  = ($urandom_range(3) != 0);
      rgap = $urandom_range(30);
      if (!rok && rgap < 8) rgap = 8;
      if (rok) model = rb;
      run_frame(rb, rok, rgap, $sformatf("rand%0d", n), rok ? 1 : 0, model);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
